// File: rtl/viterbi_simple_v2.sv
// Frame-based hard-decision Viterbi decoder for a rate-1/2 code (K, G0, G1), one trellis step per cycle.
// Define VITERBI_TERM_ZERO_EN to treat frames as zero-terminated (traceback always starts in state 0).
module viterbi_simple_v2 #(
   parameter int unsigned    K  = 3,
   parameter logic [K-1:0]   G0 = 3'b111,
   parameter logic [K-1:0]   G1 = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] frame_len,
   input  logic [1:0] syms_in [0:255],
   output logic       done,
   output logic [7:0] out_len,
   output logic       bits_out [0:255]
);

   localparam int unsigned M = K - 1;
   localparam int unsigned S = 1 << M;
   localparam logic [11:0] MAX_METRIC = 12'hFFF;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACS       = 2'd1,
      TRACEBACK = 2'd2,
      DONE      = 2'd3
   } state_t;

   state_t       state, state_d;
   logic [11:0]  metric_q [S];
   logic [11:0]  metric_d [S];
   logic [S-1:0] dec_q [256];
   logic [S-1:0] dec_row;
   logic [7:0]   t_q;
   logic [7:0]   out_len_q;
   logic [M-1:0] cur_q;
   logic [M-1:0] cur_sel;
   logic [M-1:0] tb_start;
   logic         first_q;
   logic         bits_q [256];
   logic [11:0]  min_metric;
   logic [M-1:0] min_idx;
   logic [1:0]   sym;
   logic         last_step;
   logic [M-1:0] ns_v;
   logic [11:0]  c0, c1;

   // Expected encoder output for register contents r = {previous state, input bit}.
   function automatic logic [1:0] enc_sym(input logic [K-1:0] r);
      enc_sym = {^(r & G0), ^(r & G1)};
   endfunction

   // Normalized, saturating candidate metric: predecessor metric minus previous minimum plus Hamming distance.
   function automatic logic [11:0] cand(input logic [11:0] m, input logic [11:0] mn,
                                        input logic [K-1:0] r, input logic [1:0] s);
      logic [1:0]  x;
      logic [12:0] sum;
      x   = enc_sym(r) ^ s;
      sum = {1'b0, m - mn} + {12'd0, x[1]} + {12'd0, x[0]};
      cand = sum[12] ? MAX_METRIC : sum[11:0];
   endfunction

   assign sym       = syms_in[t_q];
   assign last_step = (t_q == out_len_q - 8'd1);

   // Minimum metric serves both normalization during ACS and traceback start selection (lowest index on ties).
   always_comb begin
      min_metric = metric_q[0];
      min_idx    = '0;
      for (int i = 1; i < S; i++) begin
         if (metric_q[i] < min_metric) begin
            min_metric = metric_q[i];
            min_idx    = i[M-1:0];
         end
      end
   end

   always_comb begin
      dec_row = '0;
      ns_v    = '0;
      c0      = '0;
      c1      = '0;
      for (int ns = 0; ns < S; ns++) begin
         ns_v = ns[M-1:0];
         c0   = cand(metric_q[{1'b0, ns_v[M-1:1]}], min_metric, {1'b0, ns_v}, sym);
         c1   = cand(metric_q[{1'b1, ns_v[M-1:1]}], min_metric, {1'b1, ns_v}, sym);
         metric_d[ns] = c0;
         if (c1 < c0) begin
            metric_d[ns] = c1;
            dec_row[ns]  = 1'b1;
         end
      end
   end

`ifdef VITERBI_TERM_ZERO_EN
   assign tb_start = '0;
`else
   assign tb_start = min_idx;
`endif

   assign cur_sel = first_q ? tb_start : cur_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_d = (frame_len == 8'd0) ? DONE : ACS;
            end
         end
         ACS: begin
            if (last_step) begin
               state_d = TRACEBACK;
            end
         end
         TRACEBACK: begin
            if (t_q == 8'd0) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_q       <= '0;
         out_len_q <= '0;
         cur_q     <= '0;
         first_q   <= 1'b0;
         for (int s = 0; s < S; s++) begin
            metric_q[s] <= '0;
         end
         for (int i = 0; i < 256; i++) begin
            dec_q[i]  <= '0;
            bits_q[i] <= 1'b0;
         end
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  out_len_q <= frame_len;
                  t_q       <= '0;
                  first_q   <= 1'b0;
                  for (int s = 0; s < S; s++) begin
                     metric_q[s] <= (s == 0) ? 12'd0 : MAX_METRIC;
                  end
                  for (int i = 0; i < 256; i++) begin
                     bits_q[i] <= 1'b0;
                  end
               end
            end
            ACS: begin
               for (int s = 0; s < S; s++) begin
                  metric_q[s] <= metric_d[s];
               end
               dec_q[t_q] <= dec_row;
               // t stays on the last step so traceback starts there; first_q selects the start state once.
               if (last_step) begin
                  first_q <= 1'b1;
               end else begin
                  t_q <= t_q + 8'd1;
               end
            end
            TRACEBACK: begin
               bits_q[t_q] <= cur_sel[0];
               cur_q       <= {dec_q[t_q][cur_sel], cur_sel[M-1:1]};
               first_q     <= 1'b0;
               if (t_q != 8'd0) begin
                  t_q <= t_q - 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign done    = (state == DONE);
   assign out_len = out_len_q;
   assign bits_out = bits_q;

endmodule

// File: tb/tb_viterbi_simple_v2.sv
// Directed self-checking bench for viterbi_simple_v2: default (7,5) K=3 instance plus a K=5 instance.
module tb_viterbi_simple_v2;

   logic       clk = 1'b0;
   logic       rst_n;

   logic       start_a;
   logic [7:0] len_a;
   logic [1:0] syms_a [0:255];
   logic       done_a;
   logic [7:0] out_len_a;
   logic       bits_a [0:255];

   logic       start_b;
   logic [7:0] len_b;
   logic [1:0] syms_b [0:255];
   logic       done_b;
   logic [7:0] out_len_b;
   logic       bits_b [0:255];

   logic       msg [0:255];
   int         checks   = 0;
   int         failures = 0;

   viterbi_simple_v2 dut_a (
      .clk       (clk),
      .rst       (rst_n),
      .start     (start_a),
      .frame_len (len_a),
      .syms_in   (syms_a),
      .done      (done_a),
      .out_len   (out_len_a),
      .bits_out  (bits_a)
   );

   viterbi_simple_v2 #(.K(5), .G0(5'b11111), .G1(5'b11011)) dut_b (
      .clk       (clk),
      .rst       (rst_n),
      .start     (start_b),
      .frame_len (len_b),
      .syms_in   (syms_b),
      .done      (done_b),
      .out_len   (out_len_b),
      .bits_out  (bits_b)
   );

   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic set_msg(input logic [127:0] pat, input int n);
      for (int i = 0; i < 256; i++) begin
         msg[i] = (i < n) ? pat[i] : 1'b0;
      end
   endtask

   // (7,5) encoder from state 0; flip_hi/flip_lo pick symbols whose bit1/bit0 get inverted (-1 = none).
   task automatic load_a(input int n, input int flip_hi, input int flip_lo);
      logic [6:0] st;
      logic [6:0] r;
      st = '0;
      for (int i = 0; i < 256; i++) begin
         syms_a[i] = 2'b00;
         if (i < n) begin
            r  = {st[5:0], msg[i]} & 7'h07;
            syms_a[i] = {^(r & 7'h07), ^(r & 7'h05)};
            st = r & 7'h03;
            if (i == flip_hi) syms_a[i] = syms_a[i] ^ 2'b10;
            if (i == flip_lo) syms_a[i] = syms_a[i] ^ 2'b01;
         end
      end
   endtask

   task automatic pulse_a(input logic [7:0] n);
      len_a   = n;
      start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output int cyc, output bit ok);
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < budget) begin
         if (done_a) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
   endtask

   function automatic int bad_bits_a(input int n);
      int bad;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (bits_a[i] !== ((i < n) ? msg[i] : 1'b0)) bad++;
      end
      return bad;
   endfunction

   function automatic int ones_a();
      int c;
      c = 0;
      for (int i = 0; i < 256; i++) begin
         if (bits_a[i] !== 1'b0) c++;
      end
      return c;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset;
      checks++;
      if (done_a !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_a); end
      checks++;
      if (out_len_a !== 8'd0) begin failures++; $display("FAIL reset_out_len: got %0d want 0", out_len_a); end
      checks++;
      if (dut_a.state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", dut_a.state); end
      checks++;
      if (ones_a() !== 0) begin failures++; $display("FAIL reset_bits: nonzero bits %0d want 0", ones_a()); end
      checks++;
      if (done_b !== 1'b0) begin failures++; $display("FAIL reset_done_k5: got %b want 0", done_b); end
   endtask

   // Hand-encoded (7,5) vector: message 1,0,0,0,0,0 -> symbols 11,10,11,00,00,00.
   task automatic test_directed_syms;
      int cyc;
      bit ok;
      for (int i = 0; i < 256; i++) syms_a[i] = 2'b00;
      syms_a[0] = 2'b11;
      syms_a[1] = 2'b10;
      syms_a[2] = 2'b11;
      set_msg(128'h1, 6);
      pulse_a(8'd6);
      wait_done_a(100, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL directed_done: timeout after %0d cycles", cyc); end
      checks++;
      if (bad_bits_a(6) !== 0) begin
         failures++;
         $display("FAIL directed_bits: bad %0d bit0=%b bit1=%b want 1,0", bad_bits_a(6), bits_a[0], bits_a[1]);
      end
      checks++;
      if (out_len_a !== 8'd6) begin failures++; $display("FAIL directed_out_len: got %0d want 6", out_len_a); end
   endtask

   task automatic test_k5;
      logic [6:0] st;
      logic [6:0] r;
      int cyc;
      int bad;
      bit ok;
      st = '0;
      for (int i = 0; i < 256; i++) begin
         syms_b[i] = 2'b00;
         if (i < 32) begin
            r  = {st[5:0], (i == 16)} & 7'h1F;
            syms_b[i] = {^(r & 7'h1F), ^(r & 7'h1B)};
            st = r & 7'h0F;
         end
      end
      len_b   = 8'd32;
      start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
      checks++;
      if (dut_b.state !== 2'd1) begin failures++; $display("FAIL k5_state_acs: got %0d want 1", dut_b.state); end
      cyc = 0;
      ok  = 1'b0;
      while (!ok && cyc < 200) begin
         if (done_b) ok = 1'b1;
         else begin
            @(posedge clk);
            #1;
            cyc++;
         end
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL k5_done: timeout after %0d cycles", cyc); end
      checks++;
      if (cyc < 64 || cyc > 66) begin failures++; $display("FAIL k5_latency: got %0d want 64..66 (<=70)", cyc); end
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         if (bits_b[i] !== (i == 16)) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL k5_bits: bad %0d bit16=%b want only bit16 set", bad, bits_b[16]); end
      checks++;
      if (out_len_b !== 8'd32) begin failures++; $display("FAIL k5_out_len: got %0d want 32", out_len_b); end
   endtask

   task automatic test_zero64;
      int cyc;
      bit ok;
      set_msg(128'h0, 64);
      load_a(64, -1, -1);
      pulse_a(8'd64);
      wait_done_a(300, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL zero64_done: timeout after %0d cycles", cyc); end
      checks++;
      if (ones_a() !== 0) begin failures++; $display("FAIL zero64_bits: nonzero bits %0d want 0", ones_a()); end
      checks++;
      if (out_len_a !== 8'd64) begin failures++; $display("FAIL zero64_out_len: got %0d want 64", out_len_a); end
   endtask

   task automatic test_noisy100;
      int cyc;
      bit ok;
      set_msg(128'h9E3779B97F4A7C15F39CC0605CEDC834, 100);
      load_a(100, 20, 60);
      pulse_a(8'd100);
      wait_done_a(400, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL noisy100_done: timeout after %0d cycles", cyc); end
      checks++;
      if (cyc < 200 || cyc > 202) begin failures++; $display("FAIL noisy100_latency: got %0d want 200..202", cyc); end
      checks++;
      if (bad_bits_a(100) !== 0) begin failures++; $display("FAIL noisy100_bits: bad %0d want 0", bad_bits_a(100)); end
      checks++;
      if (out_len_a !== 8'd100) begin failures++; $display("FAIL noisy100_out_len: got %0d want 100", out_len_a); end
   endtask

   task automatic test_len0;
      pulse_a(8'd0);
      checks++;
      if (done_a !== 1'b1) begin failures++; $display("FAIL len0_done: got %b want 1", done_a); end
      checks++;
      if (out_len_a !== 8'd0) begin failures++; $display("FAIL len0_out_len: got %0d want 0", out_len_a); end
      checks++;
      if (ones_a() !== 0) begin failures++; $display("FAIL len0_bits: nonzero bits %0d want 0", ones_a()); end
   endtask

   task automatic test_mid_reset;
      int cyc;
      bit ok;
      set_msg(128'h0123456789ABCDEF00FF00FFA5A5C3C3, 32);
      load_a(32, -1, -1);
      pulse_a(8'd32);
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (dut_a.state !== 2'd1) begin failures++; $display("FAIL midrst_in_acs: got %0d want 1", dut_a.state); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (done_a !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", done_a); end
      checks++;
      if (dut_a.state !== 2'd0) begin failures++; $display("FAIL midrst_state: got %0d want 0", dut_a.state); end
      checks++;
      if (out_len_a !== 8'd0) begin failures++; $display("FAIL midrst_out_len: got %0d want 0", out_len_a); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      pulse_a(8'd32);
      wait_done_a(200, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL midrst_redo_done: timeout after %0d cycles", cyc); end
      checks++;
      if (bad_bits_a(32) !== 0) begin failures++; $display("FAIL midrst_redo_bits: bad %0d want 0", bad_bits_a(32)); end
   endtask

   task automatic test_back_to_back;
      int cyc;
      bit ok;
      set_msg(128'h9E3779B97F4A7C15F39CC0605CEDC834, 100);
      load_a(100, -1, -1);
      pulse_a(8'd100);
      wait_done_a(400, cyc, ok);
      checks++;
      if (!ok || bad_bits_a(100) !== 0) begin
         failures++;
         $display("FAIL b2b_first: done=%b bad %0d want done=1 bad 0", ok, bad_bits_a(100));
      end
      set_msg(128'hC3A50F961E2DB478, 40);
      load_a(40, -1, -1);
      pulse_a(8'd40);
      checks++;
      if (done_a !== 1'b0) begin failures++; $display("FAIL b2b_done_drop: got %b want 0", done_a); end
      checks++;
      if (ones_a() !== 0) begin failures++; $display("FAIL b2b_cleared: nonzero bits %0d want 0", ones_a()); end
      wait_done_a(200, cyc, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_second_done: timeout after %0d cycles", cyc); end
      checks++;
      if (bad_bits_a(40) !== 0) begin failures++; $display("FAIL b2b_second_bits: bad %0d want 0", bad_bits_a(40)); end
      checks++;
      if (out_len_a !== 8'd40) begin failures++; $display("FAIL b2b_out_len: got %0d want 40", out_len_a); end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      len_a   = 8'd0;
      len_b   = 8'd0;
      for (int i = 0; i < 256; i++) begin
         syms_a[i] = 2'b00;
         syms_b[i] = 2'b00;
         msg[i]    = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_directed_syms();
      test_k5();
      test_zero64();
      test_noisy100();
      test_len0();
      test_mid_reset();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/viterbi_simple_v2.md
Name: viterbi_simple_v2

Overview:
- Frame-based hard-decision Viterbi decoder for a rate-1/2 convolutional code with constraint length K and generators G0/G1.
- Accepts a whole frame of up to 256 two-bit symbols in parallel and runs add-compare-select (ACS) over all states, one trellis step per cycle.
- Then traces back one step per cycle, presents the decoded bits in parallel, and raises done.
- Sits behind a symbol buffer in the receive path; the host loads the frame, pulses start, and waits for done.

Parameters:
- K, default 3: constraint length, 3..7.
- G0, default 3'b111: generator 0, K bits. Bit i taps the input bit from i steps ago; bit 0 = current input.
- G1, default 3'b101: generator 1, same bit convention.
- M, derived as K-1: memory length. Not user-overridable.
- S, derived as 2**M: number of trellis states.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset; the whole block is in reset while rst=0.
- start  input  1  one-cycle pulse; accepted only in IDLE or DONE.
- frame_len  input  8  number of symbols to decode, 0..255; sampled on start.
- syms_in  input  unpacked array [0:255] of 2 bits  received symbols; held stable from start until done.
- done  output  1  high while decoded results are valid.
- out_len  output  8  number of valid decoded bits (= latched frame_len).
- bits_out  output  unpacked array [0:255] of 1 bit  decoded bits; bits_out[i] is the bit for symbol i.

Behaviour:
- Encoder model:
  - State st is M bits, newest bit in the LSB.
  - For input b: r = {st, b}; symbol = {^(r&G0), ^(r&G1)}, so symbol bit1 is the G0 parity and bit0 is the G1 parity.
  - Next state = {st[M-2:0], b}. Encoder starts in state 0.
- FSM register is named `state`. States: IDLE=0, ACS=1, TRACEBACK=2, DONE=3.
- Reset (rst=0): state=IDLE, done=0, out_len=0, all bits_out=0, all metrics and survivors cleared.
- start in IDLE/DONE:
  - latch frame_len into out_len; clear done and every bits_out.
  - metric[0]=0, all other metrics = max value; step counter t=0.
  - go to ACS, or go straight to DONE when frame_len=0.
  - On the cycle after the start edge, `state` reads 1.
- start in ACS or TRACEBACK is ignored.
- ACS (one step per cycle, all S states in parallel):
  - For next state ns: predecessors p0={0,ns[M-1:1]} and p1={1,ns[M-1:1]}; input bit = ns[0].
  - Branch metric = Hamming distance (0..2) between syms_in[t] and the expected symbol for r={p,ns[0]}.
  - Pick the smaller candidate metric; on a tie pick p0.
  - Store decision bit dec[t][ns] (1 means p1).
  - Metrics are 12-bit and saturating. Each step, subtract the minimum metric of the previous step from all metrics (normalization).
  - After step frame_len-1, go to TRACEBACK.
- TRACEBACK:
  - Start state = the one with minimum final metric; ties go to the lowest index.
  - Each cycle, from t=frame_len-1 down to 0: bits_out[t]=cur[0]; cur={dec[t][cur], cur[M-1:1]}.
  - After t=0, go to DONE.
- DONE:
  - done=1; bits_out and out_len are held until the next start or reset.
  - bits_out[i] for i >= frame_len is 0.
- Latency from start to done: 2*frame_len+1 cycles, +/-1. It must be at most 70 cycles for frame_len=32.
- Survivor memory is 256 x S bits, in registers.
- Reset mid-operation aborts immediately to the reset state.
- Unterminated frames are decoded by best-metric traceback; the last M bits may be wrong.

Optional Feature:
- Macro: VITERBI_TERM_ZERO_EN.
- Defined: the frame is treated as zero-terminated and traceback always starts from state 0, ignoring final metrics.
- Undefined: traceback starts from the minimum-metric state, as in Behaviour.
- All other behaviour and timing are identical in both builds.

Test Plan:
- K=5, G0=5'b11111, G1=5'b11011, 32 symbols encoding a 1 at bit 16 and 0 elsewhere, one start pulse:
  - `state`=1 one cycle after start.
  - done within 200 cycles.
  - bits_out[16]=1, every other bit in 0..31 is 0, out_len=32.
- Default K=3 (7,5), all-zero 64-symbol frame -> all bits_out 0, done asserted, out_len=64.
- K=3, random 100-bit message encoded, one symbol bit flipped at positions 20 and 60 -> all 100 bits decoded correctly.
- frame_len=0 with start -> done on the next cycle, out_len=0, bits_out all 0.
- Pull rst low mid-ACS of a 32-symbol frame -> done=0 and state=IDLE immediately; a following start decodes correctly.
- Back-to-back frames: pulse start again while in DONE -> done drops, bits_out cleared, second frame decoded independently.
